// File: rtl/pad_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pad_cfg_pkg : pad config record, field positions, sequencer states, reset  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pad_cfg_pkg;

    localparam int c_cfg_w    = 6;
    localparam int c_bit_ie   = 5;
    localparam int c_bit_oe   = 4;
    localparam int c_bit_cs   = 3;
    localparam int c_bit_sl   = 2;
    localparam int c_bit_pu   = 1;
    localparam int c_bit_pd   = 0;

    typedef struct packed {
        logic ie;
        logic oe_en;
        logic cs;
        logic sl;
        logic pu;
        logic pd;
    } pad_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GATE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COPY    = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_t;

    localparam pad_cfg_t c_rst_cfg = pad_cfg_t'(6'b100000);

    // Pull-up and pull-down fighting each other is never a legal setting.
    function automatic logic cfg_legal(input logic [c_cfg_w-1:0] cfg);
        return !(cfg[c_bit_pu] && cfg[c_bit_pd]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pad_cfg_seq : commit sequencer (gate, settle, copy, release) with counter  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pad_cfg_seq
    import pad_cfg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic commit,
    output logic gate,
    output logic copy_en,
    output logic busy,
    output logic ready
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);

    seq_state_t r_state;
    logic [7:0] r_cnt;

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            gate    <= 1'b0;
            copy_en <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (commit) begin
                        r_state <= ST_GATE;
                        gate    <= 1'b1;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                ST_GATE: begin
                    r_state <= ST_SETTLE;
                    r_cnt   <= 8'd0;
                end
                ST_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_state <= ST_COPY;
                        copy_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_COPY: begin
                    r_state <= ST_RELEASE;
                    gate    <= 1'b0;
                    copy_en <= 1'b0;
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    gate    <= 1'b0;
                    copy_en <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pad_cfg_ctrl : shadow/active pad config banks with gated commit sequence   |
// | Option macro PAD_CFG_READBACK_EN builds the active-bank read mux.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int NUM_BIDIR     = 42,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [5:0]           cfg_wdata,
    output logic                 rd_valid,
    output logic [5:0]           rd_data,
    output logic                 cfg_err,
    input  logic                 commit,
    output logic                 busy,
    input  logic [NUM_BIDIR-1:0] user_oe,
    output logic [NUM_BIDIR-1:0] bidir_oe,
    output logic [NUM_BIDIR-1:0] bidir_cs,
    output logic [NUM_BIDIR-1:0] bidir_sl,
    output logic [NUM_BIDIR-1:0] bidir_ie,
    output logic [NUM_BIDIR-1:0] bidir_pu,
    output logic [NUM_BIDIR-1:0] bidir_pd
);

    localparam logic [6:0] c_num = 7'(NUM_BIDIR);

    pad_cfg_t   r_shadow [NUM_BIDIR];
    pad_cfg_t   r_active [NUM_BIDIR];
    logic       w_gate;
    logic       w_copy_en;
    logic       w_ready;
    logic       w_accept;
    logic       w_addr_ok;
    logic [5:0] w_rd_data;

    pad_cfg_seq #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .commit  (commit),
        .gate    (w_gate),
        .copy_en (w_copy_en),
        .busy    (busy),
        .ready   (w_ready)
    );

    assign cfg_ready = w_ready & ~rst;
    assign w_accept  = cfg_valid & cfg_ready;
    assign w_addr_ok = ({1'b0, cfg_addr} < c_num);

`ifdef PAD_CFG_READBACK_EN
    assign w_rd_data = w_addr_ok ? r_active[cfg_addr] : 6'd0;
`else
    assign w_rd_data = 6'd0;
`endif

    // A write accepted together with a commit pulse lands before the later copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
                r_shadow[i] <= c_rst_cfg;
                r_active[i] <= c_rst_cfg;
            end
            rd_valid <= 1'b0;
            rd_data  <= 6'd0;
            cfg_err  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cfg_err  <= 1'b0;
            if (w_accept) begin
                if (cfg_we) begin
                    if (w_addr_ok && cfg_legal(cfg_wdata)) begin
                        r_shadow[cfg_addr] <= pad_cfg_t'(cfg_wdata);
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end else begin
                    rd_valid <= 1'b1;
                    rd_data  <= w_rd_data;
                    cfg_err  <= ~w_addr_ok;
                end
            end
            if (w_copy_en) begin
                for (int i = 0; i < NUM_BIDIR; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BIDIR; gi++) begin : g_pad
            assign bidir_oe[gi] = r_active[gi][c_bit_oe] & user_oe[gi] & ~w_gate & ~rst;
            assign bidir_cs[gi] = r_active[gi][c_bit_cs];
            assign bidir_sl[gi] = r_active[gi][c_bit_sl];
            assign bidir_ie[gi] = r_active[gi][c_bit_ie];
            assign bidir_pu[gi] = r_active[gi][c_bit_pu];
            assign bidir_pd[gi] = r_active[gi][c_bit_pd];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pad_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pad_cfg_ctrl : scenario bench for pad_cfg_ctrl with read scoreboard     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pad_cfg_ctrl;

    localparam int N = 42;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic         cfg_we = 1'b0;
    logic [5:0]   cfg_addr = 6'd0;
    logic [5:0]   cfg_wdata = 6'd0;
    logic         rd_valid;
    logic [5:0]   rd_data;
    logic         cfg_err;
    logic         commit = 1'b0;
    logic         busy;
    logic [N-1:0] user_oe = '1;
    logic [N-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

    int errors = 0;
    int checks = 0;
    logic [5:0] sh_m [64];
    logic [5:0] act_m [64];
    logic [5:0] rd_q [$];

    pad_cfg_ctrl #(.NUM_BIDIR(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .cfg_err(cfg_err),
        .commit(commit), .busy(busy), .user_oe(user_oe),
        .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
        .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_rd(input int a);
`ifdef PAD_CFG_READBACK_EN
        if (a >= N) return 6'd0;
        return act_m[a];
`else
        return 6'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            sh_m[i]  = 6'b100000;
            act_m[i] = 6'b100000;
        end
    endtask

    task automatic model_copy();
        for (int i = 0; i < 64; i++) act_m[i] = sh_m[i];
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic do_read(input logic [5:0] a, input string name);
        logic [5:0] exp;
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        rd_q.push_back(exp_rd(int'(a)));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rd_valid=%b required 1", name, rd_valid);
        end
        exp = rd_q.pop_front();
        checks++;
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s rd_data=%b required %b", name, rd_data, exp);
        end
        checks++;
        if (cfg_err !== (int'(a) >= N)) begin
            errors++;
            $display("FAIL %s cfg_err=%b required %b", name, cfg_err, int'(a) >= N);
        end
        @(negedge clk);
        checks++;
        if ({rd_valid, cfg_err} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pulse rd_valid/cfg_err=%b required 00", name, {rd_valid, cfg_err});
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [5:0] d, input logic cm, input string name);
        logic exp_err;
        exp_err = (int'(a) >= N) || (d[1] && d[0]);
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; commit = cm;
        if (!exp_err) sh_m[a] = d;
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_we = 1'b0; commit = 1'b0;
        @(negedge clk);
        checks++;
        if ({cfg_err, rd_valid} !== {exp_err, 1'b0}) begin
            errors++;
            $display("FAIL %s cfg_err/rd_valid=%b required %b", name, {cfg_err, rd_valid}, {exp_err, 1'b0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cfg_ready, busy, bidir_oe} !== '0) begin
            errors++;
            $display("FAIL rst_held ready=%b busy=%b oe=%h required all 0", cfg_ready, busy, bidir_oe);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bidir_ie !== {N{1'b1}}) begin
            errors++;
            $display("FAIL rst_ie ie=%h required all ones", bidir_ie);
        end
        checks++;
        if ({bidir_oe, bidir_cs, bidir_sl, bidir_pu, bidir_pd, rd_valid, rd_data, cfg_err, busy} !== '0) begin
            errors++;
            $display("FAIL rst_zero some pad/resp output nonzero oe=%h pu=%h rd=%b", bidir_oe, bidir_pu, rd_data);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready cfg_ready=%b required 1", cfg_ready);
        end
        do_read(6'd5, "rst_read5");
    endtask

    task automatic test_commit();
        do_write(6'd3, 6'b110000, 1'b0, "wr3");
        pulse_commit();
        for (int k = 0; k < S + 6; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k < S + 3)) begin
                errors++;
                $display("FAIL commit_busy k=%0d busy=%b required %b", k, busy, k < S + 3);
            end
            checks++;
            if (bidir_oe[3] !== (k >= S + 2)) begin
                errors++;
                $display("FAIL commit_oe3 k=%0d oe=%b required %b", k, bidir_oe[3], k >= S + 2);
            end
        end
        model_copy();
        do_read(6'd3, "rd3_after_commit");
    endtask

    task automatic test_reject();
        do_write(6'd42, 6'd0, 1'b0, "wr42_err");
        do_write(6'd0, 6'b100011, 1'b0, "wr0_pupd_err");
        pulse_commit();
        wait_idle("reject_commit");
        model_copy();
        checks++;
        if ({bidir_ie[0], bidir_pu[0], bidir_pd[0], bidir_oe[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL reject_pad0 ie/pu/pd/oe=%b required 1000",
                     {bidir_ie[0], bidir_pu[0], bidir_pd[0], bidir_oe[0]});
        end
        do_read(6'd0, "rd0_after_reject");
        do_read(6'd50, "rd50_err");
    endtask

    task automatic test_commit_ignore();
        int nbusy = 0;
        int bad_ready = 0;
        pulse_commit();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy) begin
                nbusy++;
                if (cfg_ready) bad_ready++;
            end
            if (k == 2) commit = 1'b1;
            if (k == 3) commit = 1'b0;
        end
        checks++;
        if (nbusy != S + 3) begin
            errors++;
            $display("FAIL ignore_busy_cycles got=%0d required %0d", nbusy, S + 3);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL ignore_ready cycles_ready_while_busy=%0d required 0", bad_ready);
        end
    endtask

    task automatic test_rst_copy();
        do_write(6'd7, 6'b010100, 1'b0, "wr7");
        pulse_commit();
        for (int k = 0; k <= S + 1; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, cfg_ready, bidir_oe[7], bidir_pu[7], bidir_ie[7]} !== 5'b00001) begin
            errors++;
            $display("FAIL rstcopy_held busy/ready/oe/pu/ie=%b required 00001",
                     {busy, cfg_ready, bidir_oe[7], bidir_pu[7], bidir_ie[7]});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({busy, cfg_ready, bidir_oe[7], bidir_pu[7]} !== 4'b0100) begin
            errors++;
            $display("FAIL rstcopy_idle busy/ready/oe/pu=%b required 0100",
                     {busy, cfg_ready, bidir_oe[7], bidir_pu[7]});
        end
        pulse_commit();
        wait_idle("rstcopy_recommit");
        checks++;
        if (bidir_pu[7] !== 1'b0) begin
            errors++;
            $display("FAIL rstcopy_shadow pu7=%b required 0", bidir_pu[7]);
        end
    endtask

    task automatic test_write_commit();
        do_write(6'd9, 6'b011010, 1'b1, "wr9_commit");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wc_busy busy=%b required 1", busy);
        end
        wait_idle("wc_commit");
        model_copy();
        checks++;
        if ({bidir_ie[9], bidir_oe[9], bidir_cs[9], bidir_sl[9], bidir_pu[9], bidir_pd[9]} !== 6'b011010) begin
            errors++;
            $display("FAIL wc_pad9 outputs=%b required 011010",
                     {bidir_ie[9], bidir_oe[9], bidir_cs[9], bidir_sl[9], bidir_pu[9], bidir_pd[9]});
        end
        do_read(6'd9, "rd9_after_wc");
    endtask

    task automatic test_back_to_back();
        logic [5:0] addrs [4];
        logic [5:0] exp;
        addrs[0] = 6'd3; addrs[1] = 6'd9; addrs[2] = 6'd0; addrs[3] = 6'd60;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = addrs[i];
            rd_q.push_back(exp_rd(int'(addrs[i])));
            @(posedge clk); #1;
            if (i == 3) cfg_valid = 1'b0;
            @(negedge clk);
            exp = rd_q.pop_front();
            checks++;
            if ({rd_valid, rd_data, cfg_err} !== {1'b1, exp, int'(addrs[i]) >= N}) begin
                errors++;
                $display("FAIL b2b_rd%0d valid/data/err=%b required %b", i,
                         {rd_valid, rd_data, cfg_err}, {1'b1, exp, int'(addrs[i]) >= N});
            end
        end
        @(negedge clk);
        checks++;
        if ({rd_valid, cfg_err} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle rd_valid/cfg_err=%b required 00", {rd_valid, cfg_err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_commit();
        test_reject();
        test_commit_ignore();
        test_rst_copy();
        test_write_commit();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
